// File: rtl/cgol_pkg.sv
// -----------------------------------------------------------------------------
// cgol_pkg
// Shared types and default timing for the Game of Life LED display blocks.
// The frame sequencer, ws2812b and cgol_logic all use it.
//   seq_state_t     - frame sequencer state encoding
//   gen_count_t     - 16-bit generation counter, wraps 0xFFFF -> 0
//   DEF_*_CYC       - default cycle counts for a 12 MHz clk
//   timer_width()   - counter width able to reach a given cycle count
// -----------------------------------------------------------------------------
package cgol_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE      = 3'd0,
    SEQ_CALC      = 3'd1,
    SEQ_WAIT_CALC = 3'd2,
    SEQ_STREAM    = 3'd3,
    SEQ_LATCH     = 3'd4,
    SEQ_HOLD      = 3'd5
  } seq_state_t;

  typedef logic [15:0] gen_count_t;

  localparam int DEF_GEN_PERIOD_CYC = 6_000_000;  // 0.5 s at 12 MHz
  localparam int DEF_LATCH_CYC      = 3_600;      // 300 us at 12 MHz
  localparam int DEF_TIMEOUT_CYC    = 1_000_000;

  // One spare bit above $clog2 lets a saturated timer sit past its limit.
  function automatic int timer_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/cgol_frame_sequencer_if.sv
// -----------------------------------------------------------------------------
// cgol_frame_sequencer_if
// Control, CGOL-engine handshake and pixel-stream signals of the frame
// sequencer, bundled in one place.
//   master - the sequencer: drives o_*, samples i_*
//   slave  - the environment (CGOL engine, colour/WS2812B path, controls)
// Parameter AW: pixel address width, $clog2(GRID_W*GRID_H).
// -----------------------------------------------------------------------------
interface cgol_frame_sequencer_if #(
  parameter int AW = 6
) ();
  import cgol_pkg::*;

  logic          i_run;
  logic          i_step;
  logic          o_calc_start;
  logic          i_calc_done;
  logic [AW-1:0] o_pix_addr;
  logic          o_pix_valid;
  logic          i_pix_ready;
  logic          o_frame_last;
  logic          o_busy;
  gen_count_t    o_gen_count;
  logic          o_error;

  modport master (
    input  i_run, i_step, i_calc_done, i_pix_ready,
    output o_calc_start, o_pix_addr, o_pix_valid, o_frame_last,
           o_busy, o_gen_count, o_error
  );

  modport slave (
    output i_run, i_step, i_calc_done, i_pix_ready,
    input  o_calc_start, o_pix_addr, o_pix_valid, o_frame_last,
           o_busy, o_gen_count, o_error
  );

endinterface

// File: rtl/cgol_cycle_timer.sv
// -----------------------------------------------------------------------------
// cgol_cycle_timer
// Load / count / saturate cycle timer. Sits at all-ones instead of wrapping,
// so a long stall cannot make an elapsed interval look fresh again.
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - load load_val this cycle (takes priority over en)
//   load_val   - value to load
//   en         - count up by one
//   count      - current value
// -----------------------------------------------------------------------------
module cgol_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // NOTE: clocked state uses non-blocking assignments so every register
  // updates from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cgol_frame_sequencer.sv
// -----------------------------------------------------------------------------
// cgol_frame_sequencer
// Frame sequencer for the Game of Life LED display. It starts one generation
// in the CGOL engine and waits for its done. It then streams every cell
// address in raster order over valid/ready, holds the WS2812B latch time, and
// paces generations at GEN_PERIOD_CYC. Modes are free-run (i_run), pause and
// single step (i_step).
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - cgol_frame_sequencer_if.master (run/step controls, calc
//                start/done, pixel stream, busy, gen count, error)
// Optional feature: define CGOL_CALC_TIMEOUT_EN to add a WAIT_CALC watchdog.
// When TIMEOUT_CYC cycles pass from the start pulse without a done, it sets a
// sticky o_error and returns to IDLE. o_error then blocks new generations
// until reset. Without the macro, o_error is tied 0.
// -----------------------------------------------------------------------------
module cgol_frame_sequencer
  import cgol_pkg::*;
#(
  parameter int GRID_W         = 8,
  parameter int GRID_H         = 8,
  parameter int GEN_PERIOD_CYC = DEF_GEN_PERIOD_CYC,
  parameter int LATCH_CYC      = DEF_LATCH_CYC,
  parameter int TIMEOUT_CYC    = DEF_TIMEOUT_CYC
) (
  input logic                    clk,
  input logic                    rst_n,
  cgol_frame_sequencer_if.master bus
);

  localparam int N  = GRID_W * GRID_H;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = timer_width(GEN_PERIOD_CYC);
  localparam int LW = timer_width(LATCH_CYC);

  localparam logic [AW-1:0] ADDR_LAST   = AW'(N - 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'((GEN_PERIOD_CYC > 0) ? GEN_PERIOD_CYC - 1 : 0);
  localparam logic [LW-1:0] LATCH_LAST  = LW'((LATCH_CYC > 0) ? LATCH_CYC - 1 : 0);

  localparam logic [2:0] ST_IDLE   = SEQ_IDLE;
  localparam logic [2:0] ST_CALC   = SEQ_CALC;
  localparam logic [2:0] ST_WAIT   = SEQ_WAIT_CALC;
  localparam logic [2:0] ST_STREAM = SEQ_STREAM;
  localparam logic [2:0] ST_LATCH  = SEQ_LATCH;
  localparam logic [2:0] ST_HOLD   = SEQ_HOLD;

  logic [2:0]    state, state_d;
  logic [AW-1:0] addr;
  gen_count_t    gen_count;
  logic          step_flag;
  logic          pix_fire;
  logic          timeout_hit;
  logic          error_q;
  logic [PW-1:0] period_cnt;
  logic [LW-1:0] latch_cnt;

  assign pix_fire = (state == ST_STREAM) && bus.i_pix_ready;

  // The period timer reads 0 during the CALC cycle itself. HOLD therefore
  // releases on the cycle that makes start-to-start exactly GEN_PERIOD_CYC.
  cgol_cycle_timer #(.WIDTH(PW)) u_period_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_d == ST_CALC),
    .load_val ('0),
    .en       (1'b1),
    .count    (period_cnt)
  );

  // Held at 0 outside LATCH, so it reads 0..LATCH_CYC-1 across the latch.
  cgol_cycle_timer #(.WIDTH(LW)) u_latch_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state != ST_LATCH),
    .load_val ('0),
    .en       (1'b1),
    .count    (latch_cnt)
  );

`ifdef CGOL_CALC_TIMEOUT_EN
  localparam int WW = timer_width(TIMEOUT_CYC);
  localparam logic [WW-1:0] TIMEOUT_LAST = WW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [WW-1:0] wd_cnt;

  // Counts from the start pulse (CALC) through WAIT_CALC.
  cgol_cycle_timer #(.WIDTH(WW)) u_watchdog_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (!((state == ST_CALC) || (state == ST_WAIT))),
    .load_val ('0),
    .en       (1'b1),
    .count    (wd_cnt)
  );

  // A done that arrives on the same cycle as the timeout still wins.
  assign timeout_hit = (state == ST_WAIT) && !bus.i_calc_done && (wd_cnt >= TIMEOUT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else if (timeout_hit) begin
      error_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign error_q     = 1'b0;
`endif

  // NOTE: state_d gets its default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (!error_q && (bus.i_run || bus.i_step)) state_d = ST_CALC;
      ST_CALC:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.i_calc_done)  state_d = ST_STREAM;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_STREAM: if (pix_fire && (addr == ADDR_LAST)) state_d = ST_LATCH;
      // Without i_run the frame ends after the latch; HOLD only paces free-run.
      ST_LATCH:  if (latch_cnt >= LATCH_LAST) state_d = bus.i_run ? ST_HOLD : ST_IDLE;
      ST_HOLD: begin
        if (period_cnt >= PERIOD_LAST)
          state_d = (bus.i_run && !step_flag) ? ST_CALC : ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      gen_count <= '0;
      step_flag <= 1'b0;
    end else begin
      state <= state_d;
      if ((state == ST_WAIT) && bus.i_calc_done) gen_count <= gen_count + 1'b1;
      // addr returns to 0 after the last pixel, so the next frame starts at 0.
      if (pix_fire) addr <= (addr == ADDR_LAST) ? '0 : addr + 1'b1;
      // Run has priority, so a step counts only when it arrives alone.
      if ((state == ST_IDLE) && (state_d == ST_CALC)) step_flag <= bus.i_step && !bus.i_run;
      else if (state_d == ST_IDLE)                    step_flag <= 1'b0;
    end
  end

  assign bus.o_calc_start = (state == ST_CALC);
  assign bus.o_pix_valid  = (state == ST_STREAM);
  assign bus.o_pix_addr   = addr;
  assign bus.o_frame_last = (state == ST_STREAM) && (addr == ADDR_LAST);
  assign bus.o_busy       = (state != ST_IDLE);
  assign bus.o_gen_count  = gen_count;
  assign bus.o_error      = error_q;

endmodule
